// File: rtl/jtag_ir_pkg.sv
// Shared opcode constants, select-line struct and opcode legality check for the JTAG IR.
// Parity protection of instruction loads is enabled by defining JTAG_IR_PARITY_EN.
package jtag_ir_pkg;

    localparam int EXTEST  = 0;
    localparam int IDCODE  = 1;
    localparam int SAMPLE  = 2;
    localparam int MAX_IR_W = 32;
    // Truncate to the instruction width at the point of use; the low IR_W bits are all ones.
    localparam logic [MAX_IR_W-1:0] BYPASS_ALL1 = '1;
    localparam int USER_BASE_DFLT = 8;

    typedef struct packed {
        logic bypass;
        logic idcode;
        logic sample;
        logic extest;
    } ir_sel_t;

    function automatic logic ir_supported(input logic [MAX_IR_W-1:0] op,
                                          input int ir_w,
                                          input int num_user,
                                          input int user_base);
        logic [MAX_IR_W-1:0] all1;
        logic                ok;
        all1 = BYPASS_ALL1 >> (MAX_IR_W - ir_w);
        ok = (op == MAX_IR_W'(EXTEST)) || (op == MAX_IR_W'(IDCODE)) ||
             (op == MAX_IR_W'(SAMPLE)) || (op == all1);
        if ((op >= MAX_IR_W'(user_base)) && (op < MAX_IR_W'(user_base + num_user)))
            ok = 1'b1;
        return ok;
    endfunction

endpackage

// File: rtl/jtag_ir_ctl_if.sv
// TAP-side strobes and IR outputs; the slave modport is the IR controller, master is the TAP.
// The IR_PARITY_ERR member exists only when JTAG_IR_PARITY_EN is defined.
interface jtag_ir_ctl_if #(
    parameter int IR_W     = 4,
    parameter int NUM_USER = 2
);
    localparam int UW = (NUM_USER > 0) ? NUM_USER : 1;

    // Strobes are level qualifiers on a single TCK edge: no valid/ready, each is high for exactly one TCK.
    logic            TDI;
    logic            CAPTUREIR;
    logic            SHIFTIR;
    logic            UPDATEIR;
    logic [IR_W-3:0] IR_STATUS;
    logic            INSTR_TDO;
    logic [IR_W-1:0] LATCH_JTAG_IR;
    logic            SEL_BYPASS;
    logic            SEL_IDCODE;
    logic            SEL_SAMPLE;
    logic            SEL_EXTEST;
    logic [UW-1:0]   SEL_USER;
`ifdef JTAG_IR_PARITY_EN
    logic            IR_PARITY_ERR;
`endif

    modport slave (
        input  TDI, CAPTUREIR, SHIFTIR, UPDATEIR, IR_STATUS,
        output INSTR_TDO, LATCH_JTAG_IR, SEL_BYPASS, SEL_IDCODE, SEL_SAMPLE, SEL_EXTEST, SEL_USER
`ifdef JTAG_IR_PARITY_EN
        , output IR_PARITY_ERR
`endif
    );

    modport master (
        output TDI, CAPTUREIR, SHIFTIR, UPDATEIR, IR_STATUS,
        input  INSTR_TDO, LATCH_JTAG_IR, SEL_BYPASS, SEL_IDCODE, SEL_SAMPLE, SEL_EXTEST, SEL_USER
`ifdef JTAG_IR_PARITY_EN
        , input IR_PARITY_ERR
`endif
    );

endinterface

// File: rtl/jtag_ir_decode.sv
// Combinational opcode legaliser: unsupported or parity-failed opcodes become BYPASS,
// and the legal opcode is decoded into exactly one select line.
module jtag_ir_decode
    import jtag_ir_pkg::*;
#(
    parameter int IR_W      = 4,
    parameter int NUM_USER  = 2,
    parameter int USER_BASE = USER_BASE_DFLT,
    localparam int UW       = (NUM_USER > 0) ? NUM_USER : 1
) (
    input  logic [IR_W-1:0] opcode_i,
    input  logic            parity_ok_i,
    output logic [IR_W-1:0] legal_o,
    output ir_sel_t         sel_o,
    output logic [UW-1:0]   sel_user_o
);

    logic supported;

    always_comb begin
        supported  = parity_ok_i &&
                     ir_supported(MAX_IR_W'(opcode_i), IR_W, NUM_USER, USER_BASE);
        legal_o    = supported ? opcode_i : '1;
        sel_o      = '0;
        sel_user_o = '0;
        // Fixed opcodes take precedence so a user range overlapping them cannot break one-hot.
        if (legal_o == IR_W'(EXTEST)) begin
            sel_o.extest = 1'b1;
        end else if (legal_o == IR_W'(IDCODE)) begin
            sel_o.idcode = 1'b1;
        end else if (legal_o == IR_W'(SAMPLE)) begin
            sel_o.sample = 1'b1;
        end else if (legal_o == {IR_W{1'b1}}) begin
            sel_o.bypass = 1'b1;
        end else begin
            for (int k = 0; k < NUM_USER; k++) begin
                if (legal_o == IR_W'(USER_BASE + k))
                    sel_user_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtag_ir_ctl.sv
// JTAG instruction register: capture, LSB-first shift, update with registered decode.
// Define JTAG_IR_PARITY_EN for an extra even-parity bit and the sticky IR_PARITY_ERR flag.
module jtag_ir_ctl
    import jtag_ir_pkg::*;
#(
    parameter int IR_W        = 4,
    parameter int NUM_USER    = 2,
    parameter int USER_BASE   = USER_BASE_DFLT,
    parameter int RESET_INSTR = IDCODE
) (
    input logic           TCK,
    input logic           TAP_RST,
    jtag_ir_ctl_if.slave  ir
);

`ifdef JTAG_IR_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int SR_W = IR_W + PAR_W;
    localparam int UW   = (NUM_USER > 0) ? NUM_USER : 1;

    logic [SR_W-1:0] sr_q, sr_d;
    logic [IR_W-1:0] latch_q, latch_d;
    ir_sel_t         sel_q, sel_d;
    logic [UW-1:0]   sel_user_q, sel_user_d;
    logic            perr_q, perr_d;

    logic [IR_W-1:0] dec_op;
    logic            dec_parity_ok;
    logic            parity_ok;
    logic [IR_W-1:0] dec_legal;
    ir_sel_t         dec_sel;
    logic [UW-1:0]   dec_sel_user;

`ifdef JTAG_IR_PARITY_EN
    assign parity_ok = ~(^sr_q);
`else
    assign parity_ok = 1'b1;
`endif

    // The single decoder also produces the reset selects by steering RESET_INSTR in during reset.
    assign dec_op        = TAP_RST ? IR_W'(RESET_INSTR) : sr_q[IR_W-1:0];
    assign dec_parity_ok = TAP_RST | parity_ok;

    jtag_ir_decode #(
        .IR_W      (IR_W),
        .NUM_USER  (NUM_USER),
        .USER_BASE (USER_BASE)
    ) u_decode (
        .opcode_i    (dec_op),
        .parity_ok_i (dec_parity_ok),
        .legal_o     (dec_legal),
        .sel_o       (dec_sel),
        .sel_user_o  (dec_sel_user)
    );

    always_comb begin
        sr_d = sr_q;
        if (TAP_RST) begin
            sr_d = SR_W'(2'b01);
        end else if (ir.CAPTUREIR) begin
            sr_d[IR_W-1:0] = {ir.IR_STATUS, 2'b01};
`ifdef JTAG_IR_PARITY_EN
            sr_d[SR_W-1] = perr_q;
`endif
        end else if (ir.SHIFTIR) begin
            sr_d = {ir.TDI, sr_q[SR_W-1:1]};
        end
    end

    // Update samples the pre-edge sr_q, so a coincident shift does not disturb the loaded opcode.
    always_comb begin
        latch_d    = latch_q;
        sel_d      = sel_q;
        sel_user_d = sel_user_q;
        perr_d     = perr_q;
        if (TAP_RST || ir.UPDATEIR) begin
            latch_d    = dec_legal;
            sel_d      = dec_sel;
            sel_user_d = dec_sel_user;
        end
        if (TAP_RST)
            perr_d = 1'b0;
        else if (ir.UPDATEIR && !parity_ok)
            perr_d = 1'b1;
    end

    always_ff @(posedge TCK) begin
        sr_q       <= sr_d;
        latch_q    <= latch_d;
        sel_q      <= sel_d;
        sel_user_q <= sel_user_d;
        perr_q     <= perr_d;
    end

    assign ir.INSTR_TDO     = sr_q[0];
    assign ir.LATCH_JTAG_IR = latch_q;
    assign ir.SEL_BYPASS    = sel_q.bypass;
    assign ir.SEL_IDCODE    = sel_q.idcode;
    assign ir.SEL_SAMPLE    = sel_q.sample;
    assign ir.SEL_EXTEST    = sel_q.extest;
    assign ir.SEL_USER      = sel_user_q;
`ifdef JTAG_IR_PARITY_EN
    assign ir.IR_PARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_jtag_ir_ctl.sv
// Directed bench for jtag_ir_ctl (IR_W=4, NUM_USER=2, USER_BASE=8); parity steps need JTAG_IR_PARITY_EN.
module tb_jtag_ir_ctl;

  logic tck = 1'b0;
  logic tap_rst;
  int   n_vec = 0;
  int   n_err = 0;

  jtag_ir_ctl_if #(.IR_W(4), .NUM_USER(2)) ir ();

  jtag_ir_ctl #(
    .IR_W        (4),
    .NUM_USER    (2),
    .USER_BASE   (8),
    .RESET_INSTR (1)
  ) dut (
    .TCK     (tck),
    .TAP_RST (tap_rst),
    .ir      (ir.slave)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one TCK cycle of strobes; outputs are stable 1ns after the edge.
  task automatic tick(input logic rst, input logic cap, input logic sh,
                      input logic upd, input logic tdi);
    tap_rst      = rst;
    ir.CAPTUREIR = cap;
    ir.SHIFTIR   = sh;
    ir.UPDATEIR  = upd;
    ir.TDI       = tdi;
    @(posedge tck);
    #1;
    tap_rst      = 1'b0;
    ir.CAPTUREIR = 1'b0;
    ir.SHIFTIR   = 1'b0;
    ir.UPDATEIR  = 1'b0;
  endtask

  task automatic shift_bits(input int n, input logic [7:0] val);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, val[i]);
  endtask

  // exp_sel is {bypass, idcode, sample, extest}.
  task automatic chk_ir(input string tag, input logic [3:0] exp_latch,
                        input logic [3:0] exp_sel, input logic [1:0] exp_user);
    chk({tag, "_latch"}, 32'(ir.LATCH_JTAG_IR), 32'(exp_latch));
    chk({tag, "_sel"}, 32'({ir.SEL_BYPASS, ir.SEL_IDCODE, ir.SEL_SAMPLE, ir.SEL_EXTEST}),
        32'(exp_sel));
    chk({tag, "_user"}, 32'(ir.SEL_USER), 32'(exp_user));
  endtask

  initial begin
    tap_rst      = 1'b0;
    ir.TDI       = 1'b0;
    ir.CAPTUREIR = 1'b0;
    ir.SHIFTIR   = 1'b0;
    ir.UPDATEIR  = 1'b0;
    ir.IR_STATUS = 2'b00;
    @(posedge tck);
    #1;

    // Reset held two cycles
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ir("reset", 4'h1, 4'b0100, 2'b00);
    chk("reset_tdo", 32'(ir.INSTR_TDO), 32'd1);

    // Capture status 10 then shift 0,1,0,1: TDO reads 1,0,0,1
    ir.IR_STATUS = 2'b10;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("cap_tdo0", 32'(ir.INSTR_TDO), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("shift_tdo1", 32'(ir.INSTR_TDO), 32'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("shift_tdo2", 32'(ir.INSTR_TDO), 32'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("shift_tdo3", 32'(ir.INSTR_TDO), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("shift_tdo4", 32'(ir.INSTR_TDO), 32'd0);
    chk_ir("pre_update_hold", 4'h1, 4'b0100, 2'b00);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ir("unsupported_A", 4'hF, 4'b1000, 2'b00);

    // USER1 = 9
    shift_bits(4, 8'h9);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ir("user1", 4'h9, 4'b0000, 2'b10);

    // USER0 = 8
    shift_bits(4, 8'h8);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ir("user0", 4'h8, 4'b0000, 2'b01);

    // Idle cycles keep the latched instruction
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ir("idle_hold", 4'h8, 4'b0000, 2'b01);

    // sr = 2, then shift and update on the same edge: SAMPLE from pre-edge sr, sr -> 1001
    shift_bits(4, 8'h2);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk_ir("upd_shift", 4'h2, 4'b0010, 2'b00);
    chk("upd_shift_tdo", 32'(ir.INSTR_TDO), 32'd1);

    // Explicit BYPASS opcode
    shift_bits(4, 8'hF);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ir("bypass", 4'hF, 4'b1000, 2'b00);

    // User code past NUM_USER (B) is unsupported
    shift_bits(4, 8'hB);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ir("user_oob", 4'hF, 4'b1000, 2'b00);

    // Reset after 2 of 4 shifts: partial instruction discarded, sr = 0001
    ir.IR_STATUS = 2'b11;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(2, 8'h0);
    chk("pre_rst_tdo", 32'(ir.INSTR_TDO), 32'd1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ir("mid_rst", 4'h1, 4'b0100, 2'b00);
    chk("mid_rst_tdo", 32'(ir.INSTR_TDO), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_sr_b1", 32'(ir.INSTR_TDO), 32'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_sr_b2", 32'(ir.INSTR_TDO), 32'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_sr_b3", 32'(ir.INSTR_TDO), 32'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ir("extest", 4'h0, 4'b0001, 2'b00);

    // IDCODE loaded by shifting
    shift_bits(4, 8'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ir("idcode", 4'h1, 4'b0100, 2'b00);

`ifdef JTAG_IR_PARITY_EN
    // Opcode 2 with parity bit 0 (odd total): forced to BYPASS, flag set
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_rst_flag", 32'(ir.IR_PARITY_ERR), 32'd0);
    shift_bits(5, 8'h02);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ir("par_bad", 4'hF, 4'b1000, 2'b00);
    chk("par_bad_flag", 32'(ir.IR_PARITY_ERR), 32'd1);
    // Capture loads the flag into the MSB: sr = 10001
    ir.IR_STATUS = 2'b00;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(3, 8'h0);
    chk("par_cap_b3", 32'(ir.INSTR_TDO), 32'd0);
    shift_bits(1, 8'h0);
    chk("par_cap_msb", 32'(ir.INSTR_TDO), 32'd1);
    // Good parity load; flag stays sticky
    shift_bits(5, 8'h12);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ir("par_good", 4'h2, 4'b0010, 2'b00);
    chk("par_sticky", 32'(ir.IR_PARITY_ERR), 32'd1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_clear", 32'(ir.IR_PARITY_ERR), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
